// File: rtl/decrypted_message_checker.sv
// Scans the decrypted-message RAM and reports whether every byte is 'a'..'z' or space.
// Optional fast rejection on the first illegal byte: define CHECKER_EARLY_EXIT_EN.
module decrypted_message_checker #(
   parameter int MSG_LEN = 32,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] address_d,
   output logic              wren_d,
   input  logic [DATA_W-1:0] q_d,
   output logic              checker_in_use,
   output logic              done,
   output logic              key_ok,
   output logic [ADDR_W-1:0] bad_index
);

   typedef enum logic [2:0] {IDLE, READ, WAIT, CHECK, DONE} state_t;

   // Last index compared at full width so MSG_LEN=256 stops at 255 without wrapping.
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MSG_LEN - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] i_q, i_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] bad_q, bad_d;
   logic              done_q, done_d;
   logic              ok_q, ok_d;
   logic              fail_q, fail_d;
   logic              legal;

   assign legal = (q_d >= DATA_W'('h61) && q_d <= DATA_W'('h7A)) || (q_d == DATA_W'('h20));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         i_q     <= '0;
         addr_q  <= '0;
         bad_q   <= '0;
         done_q  <= 1'b0;
         ok_q    <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         addr_q  <= addr_d;
         bad_q   <= bad_d;
         done_q  <= done_d;
         ok_q    <= ok_d;
         fail_q  <= fail_d;
      end
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      addr_d  = addr_q;
      bad_d   = bad_q;
      done_d  = done_q;
      ok_d    = ok_q;
      fail_d  = fail_q;
      case (state_q)
         IDLE: begin
            done_d = 1'b0;
            ok_d   = 1'b0;
            bad_d  = '0;
            fail_d = 1'b0;
            i_d    = '0;
            if (start) state_d = READ;
         end
         READ: begin
            addr_d  = i_q;
            state_d = WAIT;
         end
         WAIT: state_d = CHECK;
         CHECK: begin
            // Only the first illegal byte is recorded.
            if (!legal && !fail_q) begin
               fail_d = 1'b1;
               bad_d  = i_q;
            end
`ifdef CHECKER_EARLY_EXIT_EN
            if (!legal && !fail_q) begin
               state_d = DONE;
               done_d  = 1'b1;
               ok_d    = 1'b0;
            end else
`endif
            if (i_q == LAST) begin
               state_d = DONE;
               done_d  = 1'b1;
               ok_d    = ~fail_d;
            end else begin
               i_d     = i_q + 1'b1;
               state_d = READ;
            end
         end
         DONE: begin
            if (start) begin
               done_d  = 1'b0;
               ok_d    = 1'b0;
               bad_d   = '0;
               fail_d  = 1'b0;
               i_d     = '0;
               state_d = READ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign address_d      = addr_q;
   assign wren_d         = 1'b0;
   assign checker_in_use = (state_q == READ) || (state_q == WAIT) || (state_q == CHECK);
   assign done           = done_q;
   assign key_ok         = ok_q;
   assign bad_index      = bad_q;

endmodule

// File: tb/tb_decrypted_message_checker.sv
// Directed + randomized bench for decrypted_message_checker with a behavioural RAM and result model.
module tb_decrypted_message_checker;

   logic       clk = 1'b0;
   logic       reset;
   logic       start, big_start;
   logic [7:0] address_d, big_address_d;
   logic       wren_d, big_wren_d;
   logic [7:0] q_d, big_q_d;
   logic       checker_in_use, big_in_use;
   logic       done, big_done;
   logic       key_ok, big_key_ok;
   logic [7:0] bad_index, big_bad_index;

   logic [7:0] mem     [0:255];
   logic [7:0] big_mem [0:255];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   decrypted_message_checker #(.MSG_LEN(32), .ADDR_W(8), .DATA_W(8)) u_dut (
      .clk(clk), .reset(reset), .start(start), .address_d(address_d), .wren_d(wren_d),
      .q_d(q_d), .checker_in_use(checker_in_use), .done(done), .key_ok(key_ok),
      .bad_index(bad_index));

   decrypted_message_checker #(.MSG_LEN(256), .ADDR_W(8), .DATA_W(8)) u_big (
      .clk(clk), .reset(reset), .start(big_start), .address_d(big_address_d), .wren_d(big_wren_d),
      .q_d(big_q_d), .checker_in_use(big_in_use), .done(big_done), .key_ok(big_key_ok),
      .bad_index(big_bad_index));

   // Synchronous-read RAMs: data appears the cycle after the address.
   always @(posedge clk) begin
      q_d     <= mem[address_d];
      big_q_d <= big_mem[big_address_d];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit is_legal(input logic [7:0] b);
      return (b == " ") || (b >= "a" && b <= "z");
   endfunction

   // Result and timing predicted straight from the message contents.
   function automatic void model(output bit ok, output int bad, output int lat, output int max_a);
      ok = 1'b1; bad = 0;
      for (int k = 0; k < 32; k++)
         if (ok && !is_legal(mem[k])) begin ok = 1'b0; bad = k; end
`ifdef CHECKER_EARLY_EXIT_EN
      lat   = ok ? 32 * 3 : (bad + 1) * 3;
      max_a = ok ? 31 : bad;
`else
      lat   = 32 * 3;
      max_a = 31;
`endif
   endfunction

   task automatic run_scan(input string tag, input bit busy);
      bit ok; int bad, lat, max_exp;
      int n, inuse, max_a;
      bit wren_seen;
      model(ok, bad, lat, max_exp);
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check({tag, ":done_cleared"}, done, 0);
      n = 0; inuse = checker_in_use ? 1 : 0; max_a = address_d; wren_seen = wren_d;
      while (!done && n < 2000) begin
         @(posedge clk); #1;
         n++;
         start = busy && (n == 10 || n == 20);
         if (!done && checker_in_use) inuse++;
         if (wren_d) wren_seen = 1'b1;
         if (address_d > max_a) max_a = address_d;
      end
      start = 1'b0;
      check({tag, ":latency"}, n, lat);
      check({tag, ":key_ok"}, key_ok, ok);
      if (!ok) check({tag, ":bad_index"}, bad_index, bad);
      check({tag, ":in_use_cycles"}, inuse, lat);
      check({tag, ":in_use_done"}, checker_in_use, 0);
      check({tag, ":wren"}, wren_seen, 0);
      check({tag, ":max_addr"}, max_a, max_exp);
   endtask

   initial begin
      string s;
      int n, prev;
      bit back;
      reset = 1'b1; start = 1'b0; big_start = 1'b0;
      for (int k = 0; k < 256; k++) begin mem[k] = "a"; big_mem[k] = " "; end
      repeat (3) @(posedge clk);
      #1;
      check("rst:done", done, 0);
      check("rst:key_ok", key_ok, 0);
      check("rst:bad_index", bad_index, 0);
      check("rst:address", address_d, 0);
      check("rst:in_use", checker_in_use, 0);
      @(negedge clk); reset = 1'b0;

      s = "the quick brown fox jumps over a";
      for (int k = 0; k < 32; k++) mem[k] = s[k];
      run_scan("legal", 1'b0);

      for (int k = 0; k < 32; k++) mem[k] = 8'h61;
      mem[5] = 8'h7B;
      run_scan("bad5", 1'b0);

      for (int k = 0; k < 32; k++) mem[k] = 8'h7A;
      mem[0] = 8'h60; mem[31] = 8'h20;
      run_scan("bound0", 1'b0);
      mem[0] = 8'h61;
      run_scan("bound_fix", 1'b0);

      for (int k = 0; k < 32; k++) mem[k] = "m";
      mem[3] = 8'h1F; mem[10] = 8'h21;
      run_scan("multi", 1'b0);
      mem[3] = 8'h00; mem[10] = "q"; mem[20] = 8'h5A;
      run_scan("nul", 1'b0);

      for (int k = 0; k < 32; k++) mem[k] = " ";
      run_scan("busy", 1'b1);

      // Reset in the middle of a scan abandons it.
      mem[2] = 8'h7B;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (40) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("midrst:in_use", checker_in_use, 0);
      check("midrst:done", done, 0);
      check("midrst:key_ok", key_ok, 0);
      check("midrst:bad_index", bad_index, 0);
      check("midrst:address", address_d, 0);
      @(negedge clk); reset = 1'b0;
      mem[2] = " ";
      run_scan("post_rst", 1'b0);

      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 32; k++)
            if ($urandom_range(0, 15) == 0) mem[k] = 8'($urandom_range(0, 255));
            else if ($urandom_range(0, 4) == 0) mem[k] = " ";
            else mem[k] = 8'("a" + $urandom_range(0, 25));
         run_scan($sformatf("rand%0d", r), 1'b0);
      end

      // Full 256-byte message: index must stop at 255 without wrapping.
      @(negedge clk); big_start = 1'b1;
      @(posedge clk); #1 big_start = 1'b0;
      n = 0; prev = big_address_d; back = 1'b0;
      while (!big_done && n < 3000) begin
         @(posedge clk); #1;
         n++;
         if (int'(big_address_d) < prev) back = 1'b1;
         prev = big_address_d;
      end
      check("big:latency", n, 768);
      check("big:key_ok", big_key_ok, 1);
      check("big:last_addr", big_address_d, 8'hFF);
      check("big:no_wrap", back, 0);
      repeat (5) @(posedge clk);
      #1;
      check("big:addr_hold", big_address_d, 8'hFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
